// File: rtl/uart_axil_regs.sv
// AXI4-Lite register block bridging the interconnect to the UART TX/RX byte buffers.
// Optional feature macro: UART_IRQ_EN (registered level interrupt); without it o_irq is tied 0.
module uart_axil_regs #(
    parameter int                  AXI_ALEN  = 32,
    parameter int                  AXI_DLEN  = 32,
    parameter int                  AXI_SLEN  = AXI_DLEN / 8,
    parameter int                  UART_DLEN = 8,
    parameter logic [AXI_ALEN-1:0] UART_BASE = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_axi_awvalid,
    output logic                 o_axi_awready,
    input  logic [AXI_ALEN-1:0]  i_axi_awaddr,
    input  logic                 i_axi_wvalid,
    output logic                 o_axi_wready,
    input  logic [AXI_DLEN-1:0]  i_axi_wdata,
    input  logic [AXI_SLEN-1:0]  i_axi_wstrb,
    output logic                 o_axi_bvalid,
    input  logic                 i_axi_bready,
    output logic [1:0]           o_axi_bresp,
    input  logic                 i_axi_arvalid,
    output logic                 o_axi_arready,
    input  logic [AXI_ALEN-1:0]  i_axi_araddr,
    output logic                 o_axi_rvalid,
    input  logic                 i_axi_rready,
    output logic [AXI_DLEN-1:0]  o_axi_rdata,
    output logic [1:0]           o_axi_rresp,
    output logic                 o_txb_tvalid,
    input  logic                 i_txb_tready,
    output logic [UART_DLEN-1:0] o_txb_tdata,
    input  logic                 i_txb_full,
    input  logic                 i_txb_overflow,
    input  logic                 i_rxb_tvalid,
    output logic                 o_rxb_tready,
    input  logic [UART_DLEN-1:0] i_rxb_tdata,
    input  logic                 i_rxb_empty,
    input  logic                 i_rxb_overflow,
    input  logic                 i_rxb_underflow,
    output logic                 o_irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_RXDATA  = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t               wstate;
    rstate_t               rstate;
    logic                  aw_got, w_got;
    logic [AXI_ALEN-1:2]   awaddr_q;
    logic [AXI_DLEN-1:0]   wdata_q, wdata_sh;
    logic [AXI_SLEN-1:0]   wstrb_q, strb_sh;
    logic [1:0]            ctrl;
    logic                  tx_ovf, rx_ovf, rx_udf;
    logic                  tx_busy;

    logic                  wr_decode, wr_hit, strb_legal, wr_tx_ok, wr_err, wr_clr;
    logic [1:0]            wr_off;
    logic                  rd_hit;
    logic [1:0]            rd_off;
    logic [AXI_DLEN-1:0]   rd_data_n;
    logic [1:0]            rd_resp_n;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};
    assign tx_busy    = (wstate == W_DRAIN);

    // Write decode happens the cycle after both AW and W have been captured.
    assign wr_decode  = (wstate == W_IDLE) && aw_got && w_got;
    assign wr_hit     = (awaddr_q[AXI_ALEN-1:4] == UART_BASE[AXI_ALEN-1:4]);
    assign wr_off     = awaddr_q[3:2];
    // Legal strobes are a run of ones starting at bit 0: adding 1 clears every set bit.
    assign strb_legal = (wstrb_q != '0) && (((wstrb_q + AXI_SLEN'(1)) & wstrb_q) == '0);
    assign wr_tx_ok   = wr_hit && (wr_off == OFF_TXDATA) && strb_legal;
    assign wr_err     = !wr_hit || (wr_off == OFF_RXDATA) || ((wr_off == OFF_TXDATA) && !strb_legal);
    assign wr_clr     = wr_decode && wr_hit && (wr_off == OFF_STATUS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate        <= W_IDLE;
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wdata_sh      <= '0;
            strb_sh       <= '0;
            o_txb_tvalid  <= 1'b0;
            o_txb_tdata   <= '0;
            o_axi_bvalid  <= 1'b0;
            o_axi_bresp   <= RESP_OKAY;
            ctrl          <= 2'b00;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wr_decode) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        if (wr_tx_ok) begin
                            wstate       <= W_DRAIN;
                            o_txb_tvalid <= 1'b1;
                            o_txb_tdata  <= wdata_q[UART_DLEN-1:0];
                            wdata_sh     <= wdata_q >> 8;
                            strb_sh      <= wstrb_q;
                        end else begin
                            wstate       <= W_RESP;
                            o_axi_bvalid <= 1'b1;
                            o_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                            if (wr_hit && wr_off == OFF_CTRL)
                                ctrl <= wdata_q[1:0];
                        end
                    end else begin
                        if (i_axi_awvalid && o_axi_awready) begin
                            aw_got        <= 1'b1;
                            o_axi_awready <= 1'b0;
                            awaddr_q      <= i_axi_awaddr[AXI_ALEN-1:2];
                        end else if (!aw_got) begin
                            o_axi_awready <= 1'b1;
                        end
                        if (i_axi_wvalid && o_axi_wready) begin
                            w_got        <= 1'b1;
                            o_axi_wready <= 1'b0;
                            wdata_q      <= i_axi_wdata;
                            wstrb_q      <= i_axi_wstrb;
                        end else if (!w_got) begin
                            o_axi_wready <= 1'b1;
                        end
                    end
                end
                W_DRAIN: begin
                    if (o_txb_tvalid && i_txb_tready) begin
                        // strb_sh[0] is the byte just accepted; strb_sh[1] says whether another follows.
                        if (strb_sh[1]) begin
                            o_txb_tdata <= wdata_sh[UART_DLEN-1:0];
                            wdata_sh    <= wdata_sh >> 8;
                            strb_sh     <= strb_sh >> 1;
                        end else begin
                            o_txb_tvalid <= 1'b0;
                            o_axi_bvalid <= 1'b1;
                            o_axi_bresp  <= RESP_OKAY;
                            wstate       <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (i_axi_bready) begin
                        o_axi_bvalid <= 1'b0;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as a W1C wins over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= i_txb_overflow  | (tx_ovf & ~(wr_clr & wdata_q[1]));
            rx_ovf <= i_rxb_overflow  | (rx_ovf & ~(wr_clr & wdata_q[3]));
            rx_udf <= i_rxb_underflow | (rx_udf & ~(wr_clr & wdata_q[4]));
        end
    end

    assign rd_hit = (i_axi_araddr[AXI_ALEN-1:4] == UART_BASE[AXI_ALEN-1:4]);
    assign rd_off = i_axi_araddr[3:2];

    // The RX pop is a same-cycle handshake with the AR accept, so exactly one byte leaves per read.
    assign o_rxb_tready = (rstate == R_IDLE) && o_axi_arready && i_axi_arvalid &&
                          rd_hit && (rd_off == OFF_RXDATA) && i_rxb_tvalid;

    always_comb begin
        rd_data_n = '0;
        rd_resp_n = RESP_OKAY;
        if (!rd_hit) begin
            rd_resp_n = RESP_SLVERR;
        end else begin
            case (rd_off)
                OFF_RXDATA: if (i_rxb_tvalid) begin
                    rd_data_n[31]            = 1'b1;
                    rd_data_n[UART_DLEN-1:0] = i_rxb_tdata;
                end
                OFF_STATUS: rd_data_n[5:0] = {tx_busy, rx_udf, rx_ovf, i_rxb_empty, tx_ovf, i_txb_full};
                OFF_CTRL:   rd_data_n[1:0] = ctrl;
                default:    rd_data_n      = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate        <= R_IDLE;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
            o_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (o_axi_arready && i_axi_arvalid) begin
                        o_axi_arready <= 1'b0;
                        o_axi_rvalid  <= 1'b1;
                        o_axi_rdata   <= rd_data_n;
                        o_axi_rresp   <= rd_resp_n;
                        rstate        <= R_DATA;
                    end else begin
                        o_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (i_axi_rready) begin
                        o_axi_rvalid  <= 1'b0;
                        o_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            irq_q <= 1'b0;
        else
            irq_q <= (ctrl[0] & ~i_rxb_empty) | (ctrl[1] & ~i_txb_full & ~tx_busy) |
                     tx_ovf | rx_ovf | rx_udf;
    end
    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

endmodule
